// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and width helpers for the instruction fetch front end
// Optional perf counters are enabled with FETCH_PERF_EN (see instr_fetch_unit).
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH      = 1'b0,
    REDIR_WAIT = 1'b1
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int pend_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with flush
// Flush takes priority over push and pop in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - pipelined instruction fetch with prefetch FIFO and redirect handling
// Define FETCH_PERF_EN to add saturating perf_granted/perf_dropped counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUT   = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RES,
  output logic        instr_req,
  output logic [31:0] instr_adr,
  input  logic        instr_gnt,
  input  logic        instr_r_valid,
  input  logic [31:0] instr_read,
  input  logic        branch_valid,
  input  logic [31:0] branch_adr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_granted,
  output logic [31:0] perf_dropped
`endif
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = pend_width(MAX_OUT);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_adr_q, fetch_adr_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   saved_q, saved_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [PW-1:0] drop_q, drop_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [63:0]   fifo_rdata;

  logic          can_issue;
  logic          grant;
  logic          held;
  logic          resp;
  logic          discard;
  logic          keep;
  logic [31:0]   branch_tgt;

  // Slots are reserved at request time so a returning word always fits.
  assign can_issue  = (int'(fifo_count) + int'(pending_q) < DEPTH) && (int'(pending_q) < MAX_OUT);
  assign instr_req  = !RES && ((state_q == REDIR_WAIT) || can_issue);
  assign instr_adr  = fetch_adr_q;
  assign grant      = instr_req && instr_gnt;
  assign held       = instr_req && !instr_gnt;
  assign resp       = instr_r_valid && (pending_q != '0);
  assign discard    = resp && (drop_q != '0);
  assign keep       = resp && (drop_q == '0);
  assign branch_tgt = branch_adr & 32'hFFFF_FFFC;

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q     <= FETCH;
      fetch_adr_q <= BOOT_ADDR;
      resp_pc_q   <= BOOT_ADDR;
      saved_q     <= BOOT_ADDR;
      pending_q   <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      fetch_adr_q <= fetch_adr_d;
      resp_pc_q   <= resp_pc_d;
      saved_q     <= saved_d;
      pending_q   <= pending_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_adr_d = fetch_adr_q;
    resp_pc_d   = resp_pc_q;
    saved_d     = saved_q;
    pending_d   = pending_q + PW'(grant) - PW'(resp);
    drop_d      = drop_q - PW'(discard);

    if (keep) resp_pc_d = resp_pc_q + 32'(INSTR_BYTES);

    if (grant) begin
      if (state_q == REDIR_WAIT) begin
        // The held request was issued before the redirect, so its word is stale.
        fetch_adr_d = saved_q;
        drop_d      = drop_d + PW'(1);
        state_d     = FETCH;
      end else begin
        fetch_adr_d = fetch_adr_q + 32'(INSTR_BYTES);
      end
    end

    if (branch_valid) begin
      drop_d    = pending_d;
      resp_pc_d = branch_tgt;
      if (held) begin
        state_d = REDIR_WAIT;
        saved_d = branch_tgt;
      end else begin
        fetch_adr_d = branch_tgt;
        state_d     = FETCH;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (64)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RES),
    .push  (keep && !fifo_full),
    .wdata ({instr_read, resp_pc_q}),
    .pop   (out_valid && out_ready),
    .flush (branch_valid),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_instr = fifo_empty ? 32'h0 : fifo_rdata[63:32];
  assign out_pc    = fifo_empty ? 32'h0 : fifo_rdata[31:0];

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK) begin
    if (RES) begin
      perf_granted <= 32'h0;
      perf_dropped <= 32'h0;
    end else begin
      if (grant && perf_granted != 32'hFFFF_FFFF) perf_granted <= perf_granted + 32'd1;
      if (discard && perf_dropped != 32'hFFFF_FFFF) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
// Memory model answers in order; expected words are queued when responses are driven.
module tb_instr_fetch_unit;

  localparam int          DEPTH   = 4;
  localparam int          MAX_OUT = 2;
  localparam logic [31:0] BOOT    = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] adr;
    logic        stale;
  } req_t;

  logic        CLK;
  logic        RES;
  logic        instr_req;
  logic [31:0] instr_adr;
  logic        instr_gnt;
  logic        instr_r_valid;
  logic [31:0] instr_read;
  logic        branch_valid;
  logic [31:0] branch_adr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_granted;
  logic [31:0] perf_dropped;
  logic [31:0] dropped0;
`endif

  instr_fetch_unit #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .BOOT_ADDR(BOOT)) dut (
    .CLK           (CLK),
    .RES           (RES),
    .instr_req     (instr_req),
    .instr_adr     (instr_adr),
    .instr_gnt     (instr_gnt),
    .instr_r_valid (instr_r_valid),
    .instr_read    (instr_read),
    .branch_valid  (branch_valid),
    .branch_adr    (branch_adr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_granted  (perf_granted),
    .perf_dropped  (perf_dropped)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  int          grants;
  int          pops;
  req_t        mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] adr_log[$];
  logic        resp_en;
  logic        rv_stale;
  logic [31:0] rv_adr;
  logic        stale_next;
  logic        redir;
  logic [31:0] exp_adr;
  logic [31:0] saved;
  logic        prev_held;
  logic [31:0] prev_adr;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // One clock: check and model the current cycle, then drive the memory response for the next.
  task automatic cycle();
    logic        s_req;
    logic        grant;
    logic [31:0] tgt;
    logic [63:0] e;
    req_t        r;
    #1;
    if (!RES) begin
      s_req = instr_req;
      tgt   = branch_adr & 32'hFFFF_FFFC;
      if (prev_held) begin
        checks++;
        if (s_req !== 1'b1 || instr_adr !== prev_adr) begin
          failures++;
          $display("FAIL obi_hold: req=%b adr=%h, required req=1 adr=%h", s_req, instr_adr, prev_adr);
        end
      end
      if (s_req) begin
        checks++;
        if (instr_adr !== exp_adr) begin
          failures++;
          $display("FAIL fetch_adr: got %h, required %h", instr_adr, exp_adr);
        end
        checks++;
        if (mem_q.size() + int'(instr_r_valid) >= MAX_OUT) begin
          failures++;
          $display("FAIL pending_limit: req with %0d outstanding, required < %0d",
                   mem_q.size() + int'(instr_r_valid), MAX_OUT);
        end
        adr_log.push_back(instr_adr);
      end
      if (out_valid && out_ready) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected: got pc=%h instr=%h, required no word", out_pc, out_instr);
        end else begin
          e = exp_q.pop_front();
          if ({out_instr, out_pc} !== e) begin
            failures++;
            $display("FAIL out_word: got instr=%h pc=%h, required instr=%h pc=%h",
                     out_instr, out_pc, e[63:32], e[31:0]);
          end
        end
      end
      if (instr_r_valid && !rv_stale && !branch_valid) exp_q.push_back({data_of(rv_adr), rv_adr});
      grant = s_req && instr_gnt;
      if (grant) begin
        mem_q.push_back('{adr: instr_adr, stale: branch_valid || stale_next});
        stale_next = 1'b0;
        grants++;
      end
      if (branch_valid) begin
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        exp_q.delete();
        if (s_req && !instr_gnt) begin
          stale_next = 1'b1;
          saved      = tgt;
          redir      = 1'b1;
        end else begin
          exp_adr = tgt;
          redir   = 1'b0;
        end
      end else if (grant) begin
        exp_adr = redir ? saved : exp_adr + 32'd4;
        redir   = 1'b0;
      end
      prev_held = s_req && !instr_gnt;
      prev_adr  = instr_adr;
    end
    @(posedge CLK);
    #1;
    branch_valid = 1'b0;
    if (!RES && resp_en && mem_q.size() > 0) begin
      r             = mem_q.pop_front();
      instr_r_valid = 1'b1;
      instr_read    = data_of(r.adr);
      rv_adr        = r.adr;
      rv_stale      = r.stale;
    end else begin
      instr_r_valid = 1'b0;
      instr_read    = 32'h0;
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RES = 1'b1; instr_gnt = 1'b0; branch_valid = 1'b0; branch_adr = 32'h0;
    resp_en = 1'b0; out_ready = 1'b0; instr_r_valid = 1'b0; instr_read = 32'h0;
    cycle();
    cycle();
    mem_q.delete(); exp_q.delete(); adr_log.delete();
    stale_next = 1'b0; redir = 1'b0; exp_adr = BOOT; saved = BOOT;
    prev_held = 1'b0; prev_adr = BOOT; rv_stale = 1'b0; rv_adr = 32'h0;
    RES = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1; instr_gnt = 1'b0; resp_en = 1'b1; branch_valid = 1'b0;
    for (int i = 0; i < 60 && (mem_q.size() != 0 || exp_q.size() != 0 || instr_r_valid); i++) cycle();
    checks++;
    if (mem_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s: %0d words still expected, required 0", name, exp_q.size());
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL leftover_%s: out_valid=%b pc=%h, required 0", name, out_valid, out_pc);
    end
  endtask

  task automatic test_reset();
    RES = 1'b1; instr_gnt = 1'b0; branch_valid = 1'b0; branch_adr = 32'h0;
    resp_en = 1'b0; out_ready = 1'b0; instr_r_valid = 1'b0; instr_read = 32'h0;
    prev_held = 1'b0;
    cycle();
    checks++;
    if (instr_req !== 1'b0 || instr_adr !== BOOT) begin
      failures++;
      $display("FAIL reset_req: req=%b adr=%h, required 0 %h", instr_req, instr_adr, BOOT);
    end
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_out: valid=%b instr=%h pc=%h, required all 0", out_valid, out_instr, out_pc);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_granted !== 32'h0 || perf_dropped !== 32'h0) begin
      failures++;
      $display("FAIL reset_perf: %h %h, required 0 0", perf_granted, perf_dropped);
    end
`endif
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    instr_gnt = 1'b1; out_ready = 1'b1; resp_en = 1'b1; pops = 0;
    repeat (24) cycle();
    checks++;
    if (adr_log.size() < 3 || adr_log[0] !== 32'h0 || adr_log[1] !== 32'h4 || adr_log[2] !== 32'h8) begin
      failures++;
      $display("FAIL stream_adr: first addresses %h %h %h, required 0 4 8", adr_log[0], adr_log[1], adr_log[2]);
    end
    checks++;
    if (pops < 16) begin
      failures++;
      $display("FAIL stream_rate: %0d words in 24 cycles, required >= 16", pops);
    end
    drain("stream");
  endtask

  task automatic test_full();
    do_reset();
    instr_gnt = 1'b1; out_ready = 1'b0; resp_en = 1'b1; grants = 0;
    repeat (10) cycle();
    checks++;
    if (grants != DEPTH || instr_req !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_stop: grants=%0d req=%b valid=%b, required %0d 0 1", grants, instr_req, out_valid, DEPTH);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0; grants = 0;
    repeat (6) cycle();
    checks++;
    if (grants != 1) begin
      failures++;
      $display("FAIL full_refill: grants=%0d after one pop, required 1", grants);
    end
    drain("full");
  endtask

  task automatic test_redirect();
    do_reset();
    instr_gnt = 1'b1; out_ready = 1'b0; resp_en = 1'b1;
    cycle(); cycle();
    resp_en = 1'b0;
    for (int i = 0; i < 10 && !(mem_q.size() == 2 && !instr_r_valid); i++) cycle();
    checks++;
    if (mem_q.size() != 2 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL redir_setup: outstanding=%0d valid=%b, required 2 1", mem_q.size(), out_valid);
    end
`ifdef FETCH_PERF_EN
    dropped0 = perf_dropped;
`endif
    branch_valid = 1'b1; branch_adr = 32'h0000_0103;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_flush: out_valid=%b, required 0", out_valid);
    end
    resp_en = 1'b1;
    for (int i = 0; i < 20 && !out_valid; i++) cycle();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== data_of(32'h100)) begin
      failures++;
      $display("FAIL redir_target: valid=%b pc=%h instr=%h, required 1 00000100 %h",
               out_valid, out_pc, out_instr, data_of(32'h100));
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_dropped - dropped0 !== 32'd2) begin
      failures++;
      $display("FAIL redir_dropped: %0d, required 2", perf_dropped - dropped0);
    end
`endif
    drain("redirect");
  endtask

  task automatic test_redirect_wait();
    do_reset();
    instr_gnt = 1'b0; out_ready = 1'b0; resp_en = 1'b1;
`ifdef FETCH_PERF_EN
    dropped0 = perf_dropped;
`endif
    cycle();
    branch_valid = 1'b1; branch_adr = 32'h0000_0200;
    cycle();
    repeat (3) begin
      cycle();
      checks++;
      if (instr_req !== 1'b1 || instr_adr !== 32'h0) begin
        failures++;
        $display("FAIL wait_hold: req=%b adr=%h, required 1 00000000", instr_req, instr_adr);
      end
    end
    instr_gnt = 1'b1;
    cycle();
    instr_gnt = 1'b0;
    checks++;
    if (instr_req !== 1'b1 || instr_adr !== 32'h200) begin
      failures++;
      $display("FAIL wait_resume: req=%b adr=%h, required 1 00000200", instr_req, instr_adr);
    end
    instr_gnt = 1'b1;
    for (int i = 0; i < 20 && !out_valid; i++) cycle();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
      failures++;
      $display("FAIL wait_target: valid=%b pc=%h, required 1 00000200", out_valid, out_pc);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_dropped - dropped0 !== 32'd1) begin
      failures++;
      $display("FAIL wait_dropped: %0d, required 1", perf_dropped - dropped0);
    end
`endif
    drain("redirect_wait");
  endtask

  task automatic test_wrap();
    do_reset();
    instr_gnt = 1'b1; out_ready = 1'b1; resp_en = 1'b1;
    branch_valid = 1'b1; branch_adr = 32'hFFFF_FFF8;
    cycle();
    adr_log.delete();
    repeat (8) cycle();
    checks++;
    if (adr_log.size() < 3 || adr_log[0] !== 32'hFFFF_FFF8 || adr_log[1] !== 32'hFFFF_FFFC || adr_log[2] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_adr: %h %h %h, required fffffff8 fffffffc 00000000", adr_log[0], adr_log[1], adr_log[2]);
    end
    drain("wrap");
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr_gnt = 1'b1; out_ready = 1'b0; resp_en = 1'b1;
    cycle(); cycle();
    resp_en = 1'b0;
    for (int i = 0; i < 10 && !(mem_q.size() == 2 && !instr_r_valid); i++) cycle();
    RES = 1'b1;
    #1;
    checks++;
    if (instr_req !== 1'b0) begin
      failures++;
      $display("FAIL midreset_req: req=%b during reset, required 0", instr_req);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || instr_adr !== BOOT || instr_req !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: valid=%b adr=%h req=%b, required 0 %h 0", out_valid, instr_adr, instr_req, BOOT);
    end
    do_reset();
    instr_gnt = 1'b0; out_ready = 1'b1;
    instr_r_valid = 1'b1; instr_read = 32'hDEAD_BEEF; rv_stale = 1'b1;
    cycle();
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stray_resp: out_valid=%b pc=%h, required 0", out_valid, out_pc);
    end
    instr_gnt = 1'b1; resp_en = 1'b1;
    repeat (10) cycle();
    drain("reset_mid");
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      instr_gnt    = ($urandom_range(0, 3) != 0);
      resp_en      = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      branch_valid = ($urandom_range(0, 19) == 0);
      branch_adr   = $urandom;
      cycle();
    end
    drain("random");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_redirect_wait();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
